fwft_burst_reader: RTL

//  Consumer side of the shared-buffer FWFT FIFO. On a start request, pops exactly

---
 rtl/fwft_burst_reader_pkg.sv | 16 +
 rtl/fwft_burst_reader_if.sv | 31 +++
 rtl/fwft_burst_reader_skid.sv | 87 ++++++++
 rtl/fwft_burst_reader.sv | 85 ++++++++
 4 files changed

// File: rtl/fwft_burst_reader_pkg.sv
// rtl/fwft_burst_reader_pkg.sv - shared constants for the FWFT burst reader
package fwft_burst_reader_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_LEN_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [1:0] SKID_DEPTH = 2'd2;

endpackage

// File: rtl/fwft_burst_reader_if.sv
// rtl/fwft_burst_reader_if.sv - control, FIFO-side and stream-side signals of the burst reader
interface fwft_burst_reader_if
  import fwft_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LEN_W  = DEFAULT_LEN_W
) ();

  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, burst_len, fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, busy, done
  );

  modport slave (
    output start, burst_len, fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, busy, done
  );

endinterface

// File: rtl/fwft_burst_reader_skid.sv
// rtl/fwft_burst_reader_skid.sv - 2-entry {last,data} skid buffer with registered head
module rd_skid_buf #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;
  logic [1:0]        count_q, count_d;
  logic              accept;

  assign out_valid = (count_q != 2'd0);
  assign accept    = out_valid & out_ready;

  // Caller guarantees push only when count < 2, so push+accept never sees a full buffer.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    case ({push, accept})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = push_data;
          head_last_d = push_last;
          count_d     = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_data_d = push_data;
          tail_last_d = push_last;
          count_d     = 2'd2;
        end
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = push_data;
          head_last_d = push_last;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = push_data;
          tail_last_d = push_last;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
    end
  end

  assign out_data = head_data_q;
  assign out_last = head_last_q;
  assign count    = count_q;

endmodule

// File: rtl/fwft_burst_reader.sv
// rtl/fwft_burst_reader.sv - pops burst_len words from an FWFT FIFO onto a valid/ready stream
module fwft_burst_reader
  import fwft_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LEN_W  = DEFAULT_LEN_W
) (
  input logic                 clk,
  input logic                 rst,
  fwft_burst_reader_if.master bus
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       buf_count;
  logic             pop;
  logic             accept;
  logic             drained;

  // Gated by rst so a reset cycle never steals a word the FIFO must keep.
  assign pop = ~rst & (state_q == ST_READ) & ~bus.fifo_empty
             & (remaining_q != '0) & (buf_count < SKID_DEPTH);

  assign accept  = bus.m_valid & bus.m_ready;
  assign drained = (buf_count == 2'd0) | ((buf_count == 2'd1) & accept);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.burst_len;
          state_d     = (bus.burst_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (pop) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pop),
    .push_data (bus.fifo_dout),
    .push_last (remaining_q == LEN_W'(1)),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (bus.m_data),
    .out_last  (bus.m_last),
    .count     (buf_count)
  );

  assign bus.fifo_rd_en = pop;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);

endmodule
